stack_behaviour_param: RTL
==========================

Name: stack_behaviour_param

Overview:
- Parametrised LIFO stack with WIDTH-bit entries and DEPTH slots, accessed over a shared bidirectional data bus.
- Commands are PUSH, POP and GET (indexed peek from the top).
- Adds occupancy tracking (COUNT, FULL, EMPTY) and a selectable overflow policy: ring overwrite or reject.
- Used as the generic stack primitive in the lab datapath, replacing fixed 4-bit x 5 stacks.

Parameters:
- WIDTH, 4, bits per entry and width of IO_DATA.
- DEPTH, 5, number of slots (>=2, need not be a power of 2).
- IDX_W, 3, width of INDEX.
- OVERWRITE, 1, full-stack policy: 1 = PUSH discards the oldest entry; 0 = PUSH is rejected.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- IO_DATA  inout  WIDTH  bus: driven by the host on PUSH, driven by the block on POP/GET, high-Z otherwise.
- COMMAND  input  2  0=NOP, 1=PUSH, 2=POP, 3=GET.
- INDEX  input  IDX_W  GET depth below the top (0 = top).
- COUNT  output  $clog2(DEPTH+1)  number of valid entries.
- FULL  output  1  COUNT==DEPTH.
- EMPTY  output  1  COUNT==0.

Behaviour:
- Reset: asynchronous, active-high. Clears all slots, TOP pointer, COUNT and the OUT register to 0 immediately, not waiting for a clock edge. FULL=0, EMPTY=1.
- Storage: circular buffer of DEPTH slots, TOP pointer (0..DEPTH-1), COUNT register. All updates occur on the CLK rising edge.
- Bus drive: IO_DATA = OUT register while COMMAND is 2 or 3 (combinational decode), high-Z otherwise.
  - The POP/GET result is loaded into OUT at the executing edge.
  - It is valid on IO_DATA after that edge for as long as COMMAND stays 2 or 3.
  - Latency is 1 edge.
- PUSH, not full:
  - TOP <= (TOP+1) mod DEPTH.
  - mem[TOP+1] <= IO_DATA.
  - COUNT <= COUNT+1.
- PUSH, full, OVERWRITE=1: as above, but COUNT stays DEPTH. The oldest entry is overwritten.
- PUSH, full, OVERWRITE=0: no state change. Pushed data is lost.
- POP, not empty:
  - OUT <= mem[TOP].
  - TOP <= (TOP-1) mod DEPTH.
  - COUNT <= COUNT-1.
  - The slot content is left in place and is not cleared.
- POP, empty: OUT <= 0. TOP and COUNT unchanged.
- GET:
  - e = INDEX mod DEPTH.
  - OUT <= mem[(TOP - e) mod DEPTH].
  - TOP and COUNT are unchanged.
  - If e >= COUNT, the stale or reset content of that slot is returned; this is not an error.
- NOP: OUT holds its value; no state change.
- Arithmetic:
  - Pointer wrap uses compare-and-reset, not power-of-2 masking.
  - INDEX mod DEPTH uses a constant divisor.
  - All outputs are registered except the IO_DATA tri-state enable.
- RESET asserted mid-command: reset wins. The command in flight is dropped, and after release the next edge executes normally.

Optional Feature:
- Macro: STACK_ERR_FLAG_EN.
- Defined: adds output ERR (1 bit), cleared by RESET. ERR is set sticky on:
  - POP when empty;
  - PUSH when full with OVERWRITE=0;
  - PUSH when full with OVERWRITE=1 (overwrite warning).
- ERR is cleared only by RESET.
- Undefined: no ERR port. All other behaviour is identical.

Decomposition:
- Package stack_pkg:
  - enum typedef stack_cmd_t {CMD_NOP=0, CMD_PUSH=1, CMD_POP=2, CMD_GET=3};
  - functions ring_inc(ptr, depth) and ring_sub(ptr, off, depth).
- Sub-module stack_ring_ptr: owns TOP, COUNT, FULL and EMPTY. Inputs are push/pop strobes plus the policy parameter.
- The parent holds the slot array, the OUT register and the tri-state driver.

Test Plan:
- Reset; PUSH 1,2,3 -> COUNT=3, EMPTY=0. GET idx0 -> IO_DATA=3; GET idx2 -> IO_DATA=1.
- OVERWRITE=1: PUSH 1..6 -> FULL=1, COUNT=5. GET 0 -> 6; GET 4 -> 2; GET 5 -> 6 (mod wrap). ERR=1 if enabled.
- OVERWRITE=0: PUSH 1..6 -> COUNT=5. GET 0 -> 5; GET 4 -> 1. ERR=1 if enabled.
- PUSH 7,8,9; POP x4 -> IO_DATA 9,8,7 then 0. COUNT ends 0, EMPTY=1, ERR=1.
- Bus: during NOP and PUSH, the block leaves IO_DATA high-Z (check 'z with the host released). During POP/GET, the block drives it.
- PUSH 1,2 then assert RESET between edges -> COUNT=0, EMPTY=1 and OUT=0 immediately. After release, GET 0 returns 0.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared command encoding and ring-pointer arithmetic for the parametrised LIFO stack.
package stack_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_PUSH = 2'd1,
        CMD_POP  = 2'd2,
        CMD_GET  = 2'd3
    } stack_cmd_t;

    // Wrap by compare-and-reset so DEPTH need not be a power of two.
    function automatic logic [31:0] ring_inc(input logic [31:0] ptr, input logic [31:0] depth);
        logic [31:0] r;
        if (ptr == depth - 32'd1) begin
            r = 32'd0;
        end else begin
            r = ptr + 32'd1;
        end
        return r;
    endfunction

    // Callers guarantee off < depth.
    function automatic logic [31:0] ring_sub(input logic [31:0] ptr, input logic [31:0] off,
                                             input logic [31:0] depth);
        logic [31:0] r;
        if (ptr >= off) begin
            r = ptr - off;
        end else begin
            r = ptr + depth - off;
        end
        return r;
    endfunction

endpackage

// File: rtl/stack_behaviour_param_if.sv
// Command/status bundle of stack_behaviour_param; the ERR flag exists only when
// STACK_ERR_FLAG_EN is defined.
interface stack_behaviour_param_if #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned IDX_W = 3
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [1:0]       COMMAND;
    logic [IDX_W-1:0] INDEX;
    logic [CNT_W-1:0] COUNT;
    logic             FULL;
    logic             EMPTY;
`ifdef STACK_ERR_FLAG_EN
    logic             ERR;

    modport master (output COMMAND, output INDEX,
                    input COUNT, input FULL, input EMPTY, input ERR);
    modport slave  (input COMMAND, input INDEX,
                    output COUNT, output FULL, output EMPTY, output ERR);
`else
    modport master (output COMMAND, output INDEX,
                    input COUNT, input FULL, input EMPTY);
    modport slave  (input COMMAND, input INDEX,
                    output COUNT, output FULL, output EMPTY);
`endif
endinterface

// File: rtl/stack_ring_ptr.sv
// TOP pointer and occupancy tracker of the LIFO ring; OVERWRITE selects whether a
// push into a full ring advances (dropping the oldest entry) or is refused.
module stack_ring_ptr
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH     = 5,
    parameter bit          OVERWRITE = 1'b1,
    parameter int unsigned PTR_W     = $clog2(DEPTH),
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push_i,
    input  logic             pop_i,
    output logic             push_ack_o,
    output logic [PTR_W-1:0] top_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ack_s;

    // Next pointer/occupancy; push wins priority only because commands are exclusive.
    always_comb begin
        top_d      = top_q;
        count_d    = count_q;
        push_ack_s = push_i && (!full_q || OVERWRITE);
        if (push_ack_s) begin
            top_d = PTR_W'(ring_inc(32'(top_q), DEPTH));
            if (full_q) begin
                count_d = count_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_i && !empty_q) begin
            top_d   = PTR_W'(ring_sub(32'(top_q), 32'd1, DEPTH));
            count_d = count_q - CNT_W'(1);
        end else begin
            top_d   = top_q;
            count_d = count_q;
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == {CNT_W{1'b0}});
    end

    // Pointer and flag registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            top_q   <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign push_ack_o = push_ack_s;
    assign top_o      = top_q;
    assign count_o    = count_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/stack_behaviour_param.sv
// Parametrised LIFO stack on a shared tri-state data bus (PUSH/POP/GET).
// Defining STACK_ERR_FLAG_EN adds a sticky ERR flag for empty pops and full pushes.
module stack_behaviour_param
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 5,
    parameter int unsigned IDX_W     = 3,
    parameter bit          OVERWRITE = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    inout  wire  [WIDTH-1:0]       IO_DATA,
    stack_behaviour_param_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    stack_cmd_t       cmd_s;
    logic             push_s, pop_s, drive_s, push_ack_s;
    logic             full_s, empty_s;
    logic [PTR_W-1:0] top_s, wr_ptr_s, get_ptr_s, idx_e_s;
    logic [CNT_W-1:0] count_s;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] out_q, out_d;

    assign cmd_s     = stack_cmd_t'(bus.COMMAND);
    assign push_s    = (cmd_s == CMD_PUSH);
    assign pop_s     = (cmd_s == CMD_POP);
    assign drive_s   = (cmd_s == CMD_POP) || (cmd_s == CMD_GET);
    assign idx_e_s   = PTR_W'(32'(bus.INDEX) % DEPTH);
    assign wr_ptr_s  = PTR_W'(ring_inc(32'(top_s), DEPTH));
    assign get_ptr_s = PTR_W'(ring_sub(32'(top_s), 32'(idx_e_s), DEPTH));

    stack_ring_ptr #(
        .DEPTH    (DEPTH),
        .OVERWRITE(OVERWRITE),
        .PTR_W    (PTR_W),
        .CNT_W    (CNT_W)
    ) u_ptr (
        .CLK       (CLK),
        .RESET     (RESET),
        .push_i    (push_s),
        .pop_i     (pop_s),
        .push_ack_o(push_ack_s),
        .top_o     (top_s),
        .count_o   (count_s),
        .full_o    (full_s),
        .empty_o   (empty_s)
    );

    // Slot array: written only by accepted pushes; popped slots keep their data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ack_s) begin
            mem_q[wr_ptr_s] <= IO_DATA;
        end
    end

    // Result register: GET past COUNT deliberately returns whatever sits in the slot.
    always_comb begin
        out_d = out_q;
        case (cmd_s)
            CMD_POP: begin
                if (empty_s) begin
                    out_d = {WIDTH{1'b0}};
                end else begin
                    out_d = mem_q[top_s];
                end
            end
            CMD_GET: out_d = mem_q[get_ptr_s];
            default: out_d = out_q;
        endcase
    end

    // OUT register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_q <= {WIDTH{1'b0}};
        end else begin
            out_q <= out_d;
        end
    end

    assign IO_DATA   = drive_s ? out_q : {WIDTH{1'bz}};
    assign bus.COUNT = count_s;
    assign bus.FULL  = full_s;
    assign bus.EMPTY = empty_s;

`ifdef STACK_ERR_FLAG_EN
    logic err_q, err_d;

    // Sticky error: empty pop or any push into a full stack (overwrite is a warning).
    always_comb begin
        err_d = err_q;
        if ((pop_s && empty_s) || (push_s && full_s)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // ERR register, cleared only by RESET.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.ERR = err_q;
`endif

endmodule
